draw: RTL and testbench

Pixel-square renderer and VGA output stage for the game display. On request it paints an 8×8 block of one 3-bit colour into an internal 160×120 framebuffer, and continuously scans that framebuffer out as 640×480 @ 60 Hz VGA with 4× pixel replication. It sits below the per-row update logic, which supplies block coordinates and colour, and drives the board's VGA DAC pins directly.

---
 rtl/draw_pkg.sv | 46 ++++
 rtl/draw_if.sv | 14 +
 rtl/draw_vga_timing.sv | 54 +++++
 rtl/draw.sv | 133 +++++++++++++
 tb/tb_draw.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared constants and types for the block renderer and its VGA scan-out.
// VGA geometry is 640x480 @ 60 Hz driven from a 25 MHz pixel enable.
// The framebuffer is 160x120, so each stored pixel covers a 4x4 screen area.
package draw_pkg;

  // Horizontal timing, in pixel clocks
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BACK;

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BACK;

  // Framebuffer geometry and block size
  localparam logic [8:0] FB_W        = 9'd160;
  localparam logic [7:0] FB_H        = 8'd120;
  localparam int         BLOCK       = 8;
  localparam int         FB_DEPTH    = int'(FB_W) * int'(FB_H);
  localparam logic [5:0] LAST_OFFSET = 6'(BLOCK * BLOCK - 1);

  // {R,G,B}, one bit per channel
  typedef logic [2:0] colour_t;

  typedef enum logic {
    IDLE,
    DRAW
  } draw_state_t;

  // Linear framebuffer address row*160 + col, built from shifts and adds
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    logic [14:0] row_w;
    row_w = {8'd0, row};
    return (row_w << 7) + (row_w << 5) + {7'd0, col};
  endfunction

endpackage

// File: rtl/draw_if.sv
// Draw request bus from the row update logic to the renderer.
// The master holds x, y and colour steady and raises plot to request a block.
interface draw_if;
  import draw_pkg::*;

  logic [7:0] x;
  logic [6:0] y;
  colour_t    colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);

endinterface

// File: rtl/draw_vga_timing.sv
// VGA raster generator: pixel clock, horizontal/vertical counters,
// raw (unpipelined) syncs and visible flag, plus the framebuffer
// coordinates of the current screen pixel.
module draw_vga_timing
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       pix_clk,
  output logic [7:0] fb_col,
  output logic [6:0] fb_row,
  output logic       hsync,
  output logic       vsync,
  output logic       visible
);

  logic [9:0] hcount;
  logic [9:0] vcount;

  // Pixel clock at half the system clock; its high phase doubles as the pixel enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_clk <= 1'b0;
    end else begin
      pix_clk <= ~pix_clk;
    end
  end

  // Raster counters, vcount stepping whenever hcount wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_clk) begin
      if (hcount == H_TOTAL - 10'd1) begin
        hcount <= '0;
        if (vcount == V_TOTAL - 10'd1) begin
          vcount <= '0;
        end else begin
          vcount <= vcount + 10'd1;
        end
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign fb_col  = hcount[9:2];
  assign fb_row  = vcount[8:2];
  assign hsync   = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vsync   = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
  assign visible = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

endmodule

// File: rtl/draw.sv
// Block renderer and VGA output stage. A two-state FSM paints an 8x8
// block of one colour into a 160x120x3 framebuffer, clipping at the right
// and bottom edges; the framebuffer is scanned out continuously with each
// stored pixel replicated 4x4 on screen. The read and the sync/blank
// signals share one pixel of pipeline delay so they stay aligned.
module draw
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  draw_if.slave      req,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  draw_state_t state;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  colour_t     base_colour;
  logic [5:0]  offset;

  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        fb_we;
  logic [14:0] fb_waddr;

  colour_t     fb_mem [FB_DEPTH];
  colour_t     rd_data;
  logic [14:0] fb_raddr;

  logic        pix_clk;
  logic        pix_en;
  logic [7:0]  fb_col;
  logic [6:0]  fb_row;
  logic        hsync;
  logic        vsync;
  logic        visible;
  logic        hs_d;
  logic        vs_d;
  logic        vis_d;

  draw_vga_timing u_timing (
    .clk     (clk),
    .reset   (reset),
    .pix_clk (pix_clk),
    .fb_col  (fb_col),
    .fb_row  (fb_row),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible)
  );

  assign pix_en = pix_clk;

  // Draw FSM: latch the request in IDLE, then sweep 64 offsets row-major in DRAW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      base_x      <= '0;
      base_y      <= '0;
      base_colour <= '0;
      offset      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.plot) begin
            base_x      <= req.x;
            base_y      <= req.y;
            base_colour <= req.colour;
            offset      <= '0;
            state       <= DRAW;
          end
        end
        DRAW: begin
          offset <= offset + 6'd1;
          if (offset == LAST_OFFSET) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pix_x    = {1'b0, base_x} + {6'd0, offset[2:0]};
  assign pix_y    = {1'b0, base_y} + {5'd0, offset[5:3]};
  assign fb_we    = (state == DRAW) && (pix_x < FB_W) && (pix_y < FB_H);
  assign fb_waddr = fb_addr(pix_y[6:0], pix_x[7:0]);
  assign fb_raddr = fb_addr(fb_row, fb_col);

  // Framebuffer write port, one clipped pixel per clk while drawing
  always_ff @(posedge clk) begin
    if (fb_we) begin
      fb_mem[fb_waddr] <= base_colour;
    end
  end

  // Framebuffer read port, one read per pixel clock
  always_ff @(posedge clk) begin
    if (pix_en) begin
      rd_data <= fb_mem[fb_raddr];
    end
  end

  // Delay syncs and blank by one pixel to line up with the read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      vis_d <= 1'b0;
    end else if (pix_en) begin
      hs_d  <= hsync;
      vs_d  <= vsync;
      vis_d <= visible;
    end
  end

  assign VGA_CLK     = pix_clk;
  assign VGA_HS      = hs_d;
  assign VGA_VS      = vs_d;
  assign VGA_BLANK_N = vis_d;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{vis_d & rd_data[2]}};
  assign VGA_G       = {10{vis_d & rd_data[1]}};
  assign VGA_B       = {10{vis_d & rd_data[0]}};

endmodule

// File: tb/tb_draw.sv
// Self-checking bench for draw: reset state, raster timing, table-driven
// block draws with clipping, back-to-back redraws, reset abort and a few
// sampled scan-out pixels checked against a bench-side framebuffer model.
module tb_draw;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  draw_if bus ();

  draw dut (
    .clk         (clk),
    .reset       (reset),
    .req         (bus),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
    int         exp_writes;
    int         exp_first;
    int         exp_last;
  } draw_vec_t;

  typedef struct {
    int h;
    int v;
  } scan_pt_t;

  int      tests_run = 0;
  int      tests_failed = 0;
  int      edge_cnt = 0;
  int      wr_addr[$];
  colour_t wr_data[$];
  int      wr_edge[$];
  int      exp_addr[$];
  colour_t fb_model [FB_DEPTH];

  // Count clk edges since reset release and log every framebuffer write
  always @(posedge clk) begin
    if (!reset) begin
      edge_cnt = 0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if (dut.fb_we) begin
        wr_addr.push_back(int'(dut.fb_waddr));
        wr_data.push_back(dut.base_colour);
        wr_edge.push_back(edge_cnt);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not finish, edge_cnt=%0d, required finish", edge_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
  endtask

  // Drive one plot pulse; returns the edge count at which IDLE sampled it
  task automatic apply_stimulus(input logic [7:0] x, input logic [6:0] y, input colour_t c, output int start_edge);
    @(negedge clk);
    bus.x = x;
    bus.y = y;
    bus.colour = c;
    bus.plot = 1'b1;
    @(negedge clk);
    bus.plot = 1'b0;
    start_edge = edge_cnt;
  endtask

  // Expected clipped write addresses for the first 'limit' offsets of a block
  task automatic fill_expected(input int bx, input int by, input int limit);
    exp_addr.delete();
    for (int off = 0; off < limit; off++) begin
      int px, py;
      px = bx + (off % 8);
      py = by + (off / 8);
      if (px < 160 && py < 120) exp_addr.push_back(py * 160 + px);
    end
  endtask

  // Compare the write log to exp_addr and the colours (c0 before index split, c1 after)
  task automatic compare_writes(input string name, input colour_t c0, input colour_t c1, input int split);
    int addr_bad, data_bad, n;
    check_output({name, "_count"}, wr_addr.size(), exp_addr.size());
    n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    addr_bad = 0;
    data_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr[i] != exp_addr[i]) addr_bad++;
      if (wr_data[i] !== ((i < split) ? c0 : c1)) data_bad++;
    end
    check_output({name, "_addr_errs"}, addr_bad, 0);
    check_output({name, "_data_errs"}, data_bad, 0);
    for (int i = 0; i < exp_addr.size(); i++) fb_model[exp_addr[i]] = (i < split) ? c0 : c1;
  endtask

  function automatic logic [32:0] exp_scan(input int h, input int v);
    logic    vis, hs, vs;
    colour_t c;
    vis = (h < 640) && (v < 480);
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= 490 && v < 492);
    c   = vis ? fb_model[(v / 4) * 160 + (h / 4)] : 3'b000;
    return {hs, vs, vis, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  draw_vec_t vecs[5];
  scan_pt_t  pts[10];

  initial begin
    int cnt, cnt2, start_edge;

    for (int i = 0; i < FB_DEPTH; i++) fb_model[i] = 3'b000;

    vecs[0] = '{x: 8'd16,  y: 7'd8,   colour: 3'b100, exp_writes: 64, exp_first: 1296,  exp_last: 2423};
    vecs[1] = '{x: 8'd156, y: 7'd116, colour: 3'b010, exp_writes: 16, exp_first: 18716, exp_last: 19199};
    vecs[2] = '{x: 8'd159, y: 7'd0,   colour: 3'b111, exp_writes: 8,  exp_first: 159,   exp_last: 1279};
    vecs[3] = '{x: 8'd0,   y: 7'd119, colour: 3'b011, exp_writes: 8,  exp_first: 19040, exp_last: 19047};
    vecs[4] = '{x: 8'd152, y: 7'd112, colour: 3'b110, exp_writes: 64, exp_first: 18072, exp_last: 19199};

    pts[0] = '{h: 10,  v: 5};
    pts[1] = '{h: 172, v: 8};
    pts[2] = '{h: 176, v: 8};
    pts[3] = '{h: 700, v: 20};
    pts[4] = '{h: 63,  v: 32};
    pts[5] = '{h: 64,  v: 32};
    pts[6] = '{h: 95,  v: 32};
    pts[7] = '{h: 96,  v: 32};
    pts[8] = '{h: 640, v: 33};
    pts[9] = '{h: 80,  v: 40};

    bus.x = '0;
    bus.y = '0;
    bus.colour = '0;
    bus.plot = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_hs", VGA_HS, 1);
    check_output("reset_vs", VGA_VS, 1);
    check_output("reset_blank_n", VGA_BLANK_N, 0);
    check_output("reset_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check_output("reset_vga_clk", VGA_CLK, 0);
    check_output("reset_sync_n", VGA_SYNC_N, 1);
    check_output("reset_state", dut.state, IDLE);

    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output($sformatf("vga_clk_toggle_%0d", i), VGA_CLK, (i % 2 == 0) ? 1 : 0);
    end

    // Horizontal timing from the free-running raster
    cnt = 0;
    while (VGA_HS && cnt < 4000) begin @(negedge clk); cnt++; end
    check_output("hs_first_fall_edge", edge_cnt, 1314);
    cnt = 0;
    while (!VGA_HS && cnt < 4000) begin @(negedge clk); cnt++; end
    check_output("hs_low_clks", cnt, 192);
    cnt2 = 0;
    while (VGA_HS && cnt2 < 4000) begin @(negedge clk); cnt2++; end
    check_output("line_period_clks", cnt + cnt2, 1600);
    cnt = 0;
    while (!VGA_BLANK_N && cnt < 4000) begin @(negedge clk); cnt++; end
    check_output("blank_rise_edge", edge_cnt, 3202);
    cnt = 0;
    while (VGA_BLANK_N && cnt < 4000) begin @(negedge clk); cnt++; end
    check_output("blank_high_clks", cnt, 1280);
    check_output("vs_high_early_lines", VGA_VS, 1);

    // Table-driven block draws, including clipped ones
    for (int k = 0; k < 5; k++) begin
      clear_log();
      apply_stimulus(vecs[k].x, vecs[k].y, vecs[k].colour, start_edge);
      repeat (63) @(negedge clk);
      check_output($sformatf("vec%0d_still_draw", k), dut.state, DRAW);
      @(negedge clk);
      check_output($sformatf("vec%0d_idle_after", k), dut.state, IDLE);
      repeat (2) @(negedge clk);
      check_output($sformatf("vec%0d_writes", k), wr_addr.size(), vecs[k].exp_writes);
      if (wr_addr.size() > 0) begin
        check_output($sformatf("vec%0d_first_addr", k), wr_addr[0], vecs[k].exp_first);
        check_output($sformatf("vec%0d_last_addr", k), wr_addr[wr_addr.size()-1], vecs[k].exp_last);
        check_output($sformatf("vec%0d_last_edge_le", k), wr_edge[wr_edge.size()-1] <= start_edge + 64, 1);
      end
      if (vecs[k].exp_writes == 64 && wr_edge.size() == 64) begin
        check_output($sformatf("vec%0d_first_edge", k), wr_edge[0], start_edge + 1);
        check_output($sformatf("vec%0d_final_edge", k), wr_edge[63], start_edge + 64);
      end
      fill_expected(int'(vecs[k].x), int'(vecs[k].y), 64);
      compare_writes($sformatf("vec%0d", k), vecs[k].colour, vecs[k].colour, 64);
    end

    // plot held high: colour and position sampled only at each square start
    clear_log();
    @(negedge clk);
    bus.x = 8'd0;
    bus.y = 7'd0;
    bus.colour = 3'b101;
    bus.plot = 1'b1;
    @(negedge clk);
    start_edge = edge_cnt;
    bus.colour = 3'b011;
    while (edge_cnt < start_edge + 70) @(negedge clk);
    bus.x = 8'd50;
    bus.y = 7'd50;
    bus.colour = 3'b110;
    while (edge_cnt < start_edge + 100) @(negedge clk);
    bus.plot = 1'b0;
    while (edge_cnt < start_edge + 140) @(negedge clk);
    check_output("held_idle_end", dut.state, IDLE);
    if (wr_edge.size() == 128) begin
      check_output("held_sq1_last_edge", wr_edge[63], start_edge + 64);
      check_output("held_sq2_first_edge", wr_edge[64], start_edge + 66);
    end
    fill_expected(0, 0, 64);
    for (int i = 0; i < 64; i++) exp_addr.push_back(exp_addr[i]);
    compare_writes("held", 3'b101, 3'b011, 64);

    // Reset asserted mid-draw at offset 20
    clear_log();
    apply_stimulus(8'd40, 7'd0, 3'b001, start_edge);
    while (edge_cnt < start_edge + 20) @(negedge clk);
    check_output("abort_offset", dut.offset, 20);
    reset = 1'b0;
    #1;
    check_output("abort_state_idle", dut.state, IDLE);
    repeat (10) @(negedge clk);
    fill_expected(40, 0, 20);
    compare_writes("abort", 3'b001, 3'b001, 20);
    cnt = 0;
    for (int i = 0; i < exp_addr.size(); i++) if (dut.fb_mem[exp_addr[i]] !== 3'b001) cnt++;
    check_output("abort_retained_errs", cnt, 0);
    check_output("abort_next_pixel_unwritten", dut.fb_mem[364], 3'b000);

    // Scan-out of sampled screen pixels against the framebuffer model
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int target;
      target = 2 * (pts[k].v * 800 + pts[k].h + 1);
      while (edge_cnt < target) @(negedge clk);
      check_output($sformatf("scan_%0d_%0d", pts[k].h, pts[k].v),
                   {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
                   exp_scan(pts[k].h, pts[k].v));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
